// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
// Frame sequencer and digital CDS readout for a ramp-compare pixel array.
// Drives the erase / expose / corr / convert phases, generates the shared
// ramp count, latches the ramp value at each pixel's first comparator trip,
// then streams MAX - (data - corr) (saturated) per pixel over valid/ready.
//
// State table
//   state       | meaning
//   S_IDLE      | waiting for start; captures cds_en / expose_cycles, clears latches
//   S_ERASE     | erase=1 for ERASE_CYCLES cycles
//   S_EXPOSE    | expose=1 for max(expose_cycles,1) cycles
//   S_CORR_CONV | reset-level ramp (corr=1, convert=1), latches into corr_reg
//   S_SIG_CONV  | signal ramp (convert=1), latches into data_reg
//   S_READOUT   | presents pixels 0..PIXEL_COUNT-1 over valid/ready
//   S_DONE      | one-cycle frame_done pulse, busy already low
//
// Ports
//   clk, reset (async, active-low)          clock and reset
//   start, cds_en, expose_cycles            frame request and its configuration
//   pixel_cmp                               per-pixel comparator outputs
//   erase, expose, corr, convert            array phase controls
//   ramp_count                              shared ramp value (0 outside conversion)
//   busy, frame_done                        frame status
//   out_valid, out_ready, out_data, out_index  result stream
module pixel_frame_sequencer #(
  parameter int PIXEL_COUNT   = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int ERASE_CYCLES  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           cds_en,
  input  logic [15:0]                    expose_cycles,
  input  logic [PIXEL_COUNT-1:0]         pixel_cmp,
  output logic                           erase,
  output logic                           expose,
  output logic                           corr,
  output logic                           convert,
  output logic [COUNTER_WIDTH-1:0]       ramp_count,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COUNTER_WIDTH-1:0]       out_data,
  output logic [$clog2(PIXEL_COUNT)-1:0] out_index,
  output logic                           frame_done
);

  localparam int IDX_W = $clog2(PIXEL_COUNT);
  localparam logic [COUNTER_WIDTH-1:0] MAX = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_COUNT - 1);
  localparam logic [15:0] ERASE_LAST = 16'(ERASE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CORR_CONV,
    S_SIG_CONV,
    S_READOUT,
    S_DONE
  } state_t;

  state_t                   state;
  logic [15:0]              timer;
  logic [15:0]              expose_len;
  logic                     cds_mode;
  logic [COUNTER_WIDTH-1:0] corr_reg [PIXEL_COUNT];
  logic [COUNTER_WIDTH-1:0] data_reg [PIXEL_COUNT];
  logic [PIXEL_COUNT-1:0]   tripped;
  logic [PIXEL_COUNT-1:0]   trip;
  logic                     conv_phase;
  logic                     ramp_last;
  logic [COUNTER_WIDTH-1:0] first_result;
  logic [COUNTER_WIDTH-1:0] next_result;
  logic [IDX_W-1:0]         next_idx;

  function automatic logic [COUNTER_WIDTH-1:0] cds_result(
    input logic [COUNTER_WIDTH-1:0] d,
    input logic [COUNTER_WIDTH-1:0] c
  );
    if (d >= c) return MAX - (d - c);
    else        return MAX;
  endfunction

  always_comb begin
    conv_phase = (state == S_CORR_CONV) || (state == S_SIG_CONV);
    ramp_last  = (ramp_count == MAX);
    // Only the first rising comparator in a phase is captured.
    trip       = conv_phase ? (pixel_cmp & ~tripped) : '0;
    // Pixel 0 result must be ready the edge its own last-cycle latch happens.
    first_result = cds_result(trip[0] ? ramp_count : data_reg[0], corr_reg[0]);
    next_idx     = out_index + 1'b1;
    next_result  = cds_result(data_reg[next_idx], corr_reg[next_idx]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      expose_len <= '0;
      cds_mode   <= 1'b0;
      tripped    <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      corr       <= 1'b0;
      convert    <= 1'b0;
      ramp_count <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < PIXEL_COUNT; i++) begin
        corr_reg[i] <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cds_mode   <= cds_en;
            expose_len <= (expose_cycles == 16'd0) ? 16'd1 : expose_cycles;
            tripped    <= '0;
            for (int i = 0; i < PIXEL_COUNT; i++) begin
              corr_reg[i] <= '0;
              data_reg[i] <= '0;
            end
            timer <= ERASE_LAST;
            erase <= 1'b1;
            busy  <= 1'b1;
            state <= S_ERASE;
          end
        end

        S_ERASE: begin
          if (timer == 16'd0) begin
            erase  <= 1'b0;
            expose <= 1'b1;
            timer  <= expose_len - 16'd1;
            state  <= S_EXPOSE;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        S_EXPOSE: begin
          if (timer == 16'd0) begin
            expose     <= 1'b0;
            convert    <= 1'b1;
            ramp_count <= '0;
            tripped    <= '0;
            // Preloading MAX makes a pixel that never trips read back as MAX.
            if (cds_mode) begin
              corr <= 1'b1;
              for (int i = 0; i < PIXEL_COUNT; i++) corr_reg[i] <= MAX;
              state <= S_CORR_CONV;
            end else begin
              for (int i = 0; i < PIXEL_COUNT; i++) data_reg[i] <= MAX;
              state <= S_SIG_CONV;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end

        S_CORR_CONV: begin
          for (int i = 0; i < PIXEL_COUNT; i++)
            if (trip[i]) corr_reg[i] <= ramp_count;
          if (ramp_last) begin
            corr       <= 1'b0;
            ramp_count <= '0;
            tripped    <= '0;
            for (int i = 0; i < PIXEL_COUNT; i++) data_reg[i] <= MAX;
            state <= S_SIG_CONV;
          end else begin
            tripped    <= tripped | trip;
            ramp_count <= ramp_count + 1'b1;
          end
        end

        S_SIG_CONV: begin
          for (int i = 0; i < PIXEL_COUNT; i++)
            if (trip[i]) data_reg[i] <= ramp_count;
          tripped <= tripped | trip;
          if (ramp_last) begin
            convert    <= 1'b0;
            ramp_count <= '0;
            out_valid  <= 1'b1;
            out_index  <= '0;
            out_data   <= first_result;
            state      <= S_READOUT;
          end else begin
            ramp_count <= ramp_count + 1'b1;
          end
        end

        S_READOUT: begin
          if (out_ready) begin
            if (out_index == LAST_IDX) begin
              out_valid  <= 1'b0;
              out_data   <= '0;
              out_index  <= '0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= S_DONE;
            end else begin
              out_index <= next_idx;
              out_data  <= next_result;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// tb_pixel_frame_sequencer
// Directed frames against pixel_frame_sequencer with default parameters.
// A comparator model trips each pixel when ramp_count reaches a chosen
// threshold; expected results are hand-computed and queued per frame, and a
// negedge monitor pops and compares every transfer, also checking hold under
// backpressure, back-to-back indices and per-frame phase lengths.
module tb_pixel_frame_sequencer;
  localparam int P  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cds_en = 1'b0;
  logic [15:0]   expose_cycles = 16'd0;
  logic [P-1:0]  pixel_cmp;
  logic          erase, expose, corr, convert, busy, out_valid, frame_done;
  logic [CW-1:0] ramp_count, out_data;
  logic [1:0]    out_index;
  logic          out_ready = 1'b1;

  pixel_frame_sequencer #(.PIXEL_COUNT(P), .COUNTER_WIDTH(CW), .ERASE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .cds_en(cds_en),
    .expose_cycles(expose_cycles), .pixel_cmp(pixel_cmp),
    .erase(erase), .expose(expose), .corr(corr), .convert(convert),
    .ramp_count(ramp_count), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Comparator model: trips once ramp reaches threshold; 256 never trips.
  int thr_corr[P];
  int thr_sig[P];
  always_comb begin
    for (int i = 0; i < P; i++)
      pixel_cmp[i] = convert && (int'(ramp_count) >= (corr ? thr_corr[i] : thr_sig[i]));
  end

  typedef struct packed {
    logic [1:0]    idx;
    logic [CW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  // Backpressure driver: hold out_ready low for 3 cycles on pixel 1.
  bit bp_mode = 1'b0;
  int bp_left = 0;
  always @(posedge clk) begin
    #1;
    if (bp_mode && out_valid && out_index == 2'd1 && bp_left > 0) begin
      out_ready = 1'b0;
      bp_left--;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Per-frame phase counters.
  bit counting = 1'b0;
  int cnt_erase, cnt_expose, cnt_corr, cnt_conv, cnt_busy, cnt_done, cnt_ramp_bad;

  logic          prev_v = 1'b0, prev_r = 1'b0;
  logic [CW-1:0] prev_d = '0;
  logic [1:0]    prev_i = '0;

  always @(negedge clk) begin
    if (counting) begin
      cnt_erase  += int'(erase);
      cnt_expose += int'(expose);
      cnt_corr   += int'(corr);
      cnt_conv   += int'(convert);
      cnt_busy   += int'(busy);
      cnt_done   += int'(frame_done);
      if (!convert && ramp_count != '0) cnt_ramp_bad++;
    end
    if (reset) begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(prev_d));
        chk("hold_index", int'(out_index), int'(prev_i));
      end
      if (prev_v && prev_r) begin
        if (prev_i == 2'd3) begin
          chk("done_after_last", int'({frame_done, out_valid}), 2);
        end else begin
          chk("next_valid", int'(out_valid), 1);
          chk("next_index", int'(out_index), int'(prev_i) + 1);
        end
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_index", int'(out_index), int'(e.idx));
          chk("out_data", int'(out_data), int'(e.data));
        end
      end
    end
    prev_v = out_valid && reset;
    prev_r = out_ready;
    prev_d = out_data;
    prev_i = out_index;
  end

  task automatic push_exp(input int d0, input int d1, input int d2, input int d3);
    int d[P];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < P; i++) sbq.push_back('{idx: 2'(i), data: CW'(d[i])});
  endtask

  task automatic run_frame(input bit cds, input logic [15:0] ec, input int exp_expose,
                           input int exp_busy, input bit poke_start);
    int guard;
    cnt_erase = 0; cnt_expose = 0; cnt_corr = 0; cnt_conv = 0;
    cnt_busy = 0; cnt_done = 0; cnt_ramp_bad = 0;
    counting = 1'b1;
    @(posedge clk); #1;
    cds_en = cds;
    expose_cycles = ec;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_to_busy_erase", int'({busy, erase}), 3);
    if (poke_start) begin
      guard = 0;
      while (!convert && guard < 400) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!convert) chk("convert_timeout", 0, 1);
      start = 1'b1;
      cds_en = ~cds;
      expose_cycles = 16'd7;
      @(posedge clk); #1;
      start = 1'b0;
    end
    guard = 0;
    while (!frame_done && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!frame_done) chk("frame_done_timeout", 0, 1);
    @(posedge clk); #1;
    counting = 1'b0;
    chk("erase_cycles", cnt_erase, 4);
    chk("expose_cycles", cnt_expose, exp_expose);
    chk("corr_cycles", cnt_corr, cds ? 256 : 0);
    chk("convert_cycles", cnt_conv, cds ? 512 : 256);
    chk("busy_cycles", cnt_busy, exp_busy);
    chk("frame_done_pulses", cnt_done, 1);
    chk("ramp_outside_conv", cnt_ramp_bad, 0);
  endtask

  initial begin
    int bs;
    int guard;
    // Reset state
    #1 reset = 1'b0;
    #1;
    chk("reset_outputs",
        int'({erase, expose, corr, convert, busy, out_valid, frame_done,
              ramp_count, out_data, out_index}), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    bs = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) bs++;
    end
    chk("idle_busy_cycles", bs, 0);

    // CDS off, thresholds 10/50/200/never
    thr_sig = '{10, 50, 200, 256};
    thr_corr = '{256, 256, 256, 256};
    push_exp(245, 205, 55, 0);
    run_frame(1'b0, 16'd2, 2, 4 + 2 + 256 + 4, 1'b0);

    // CDS on
    thr_corr = '{5, 40, 20, 256};
    thr_sig  = '{105, 30, 220, 256};
    push_exp(155, 255, 55, 255);
    run_frame(1'b1, 16'd3, 3, 4 + 3 + 512 + 4, 1'b0);

    // Backpressure on pixel 1, expose_cycles=0, boundary thresholds
    thr_sig = '{0, 255, 128, 1};
    push_exp(255, 0, 127, 254);
    bp_mode = 1'b1;
    bp_left = 3;
    run_frame(1'b0, 16'd0, 1, 4 + 1 + 256 + 4 + 3, 1'b0);
    bp_mode = 1'b0;

    // Start pulse during conversion is ignored
    thr_sig = '{10, 50, 200, 256};
    push_exp(245, 205, 55, 0);
    run_frame(1'b0, 16'd3, 3, 4 + 3 + 256 + 4, 1'b1);
    bs = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) bs++;
    end
    chk("no_queued_start", bs, 0);

    // Reset mid-EXPOSE
    thr_corr = '{7, 7, 7, 7};
    thr_sig  = '{9, 9, 9, 9};
    @(posedge clk); #1;
    cds_en = 1'b1;
    expose_cycles = 16'd50;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!expose && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("expose_reached", int'(expose), 1);
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_expose_busy", int'({expose, busy}), 0);
    chk("abort_outputs",
        int'({erase, expose, corr, convert, busy, out_valid, frame_done,
              ramp_count, out_data, out_index}), 0);
    @(posedge clk); #1 reset = 1'b1;

    // Clean frame after reset
    thr_sig = '{100, 0, 255, 30};
    push_exp(155, 255, 0, 225);
    run_frame(1'b0, 16'd1, 1, 4 + 1 + 256 + 4, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
